// File: rtl/dra_multi_peri.sv
// Peripheral-bus controller for up to 8 DRA channels: guarded start/reset
// control, timed reset pulses, done-edge interrupts and a version register.
module dra_multi_peri #(
  parameter int          N_CH      = 4,
  parameter logic [15:0] GUARD_KEY = 16'h1234,
  parameter int          GUARD_TMO = 255,
  parameter int          RST_PULSE = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic [N_CH-1:0] o_reset_en,
  output logic [N_CH-1:0] o_start_en,
  input  logic [N_CH-1:0] i_done,
  input  logic            i_peri_rden,
  input  logic            i_peri_wren,
  input  logic [31:0]     i_peri_addr,
  input  logic [31:0]     i_peri_wdata,
  input  logic [3:0]      i_peri_wstrb,
  output logic [31:0]     o_peri_rdata,
  output logic            o_peri_ready,
  output logic            o_peri_int
);

  // Bus handshake: every cycle with rden|wren is acknowledged by a one-cycle
  // o_peri_ready pulse on the following cycle; read data is valid with it.
  localparam logic [3:0]  IDX_GUARD = 4'd0;
  localparam logic [3:0]  IDX_START = 4'd1;
  localparam logic [3:0]  IDX_RESET = 4'd2;
  localparam logic [3:0]  IDX_STAT  = 4'd3;
  localparam logic [3:0]  IDX_MASK  = 4'd4;
  localparam logic [3:0]  IDX_VER   = 4'd5;
  localparam logic [15:0] TMO_VAL   = 16'(GUARD_TMO);
  localparam logic [7:0]  PULSE_VAL = 8'(RST_PULSE);
  localparam logic [7:0]  NCH8      = 8'(N_CH);

  logic [15:0]     r_guard;
  logic [15:0]     r_relock_cnt;
  logic [7:0]      r_pulse_cnt [N_CH];
  logic [N_CH-1:0] r_done_q;
  logic [N_CH-1:0] r_done_stat;
  logic            r_viol;
  logic [N_CH-1:0] r_mask_ch;
  logic            r_mask_viol;

  logic [3:0]      w_idx;
  logic            w_wr_ok;
  logic            w_unlocked;
  logic            w_wr_guard;
  logic            w_wr_start;
  logic            w_wr_reset;
  logic            w_wr_stat;
  logic            w_wr_mask;
  logic            w_start_acc;
  logic            w_reset_acc;
  logic            w_viol_set;
  logic [N_CH-1:0] w_done_rise;
  logic [31:0]     w_int_stat;
  logic [31:0]     w_mask_rd;
  logic [31:0]     w_rd_mux;
  logic            w_unused_bits;

  assign w_idx       = i_peri_addr[5:2];
  assign w_wr_ok     = i_peri_wren && (i_peri_wstrb == 4'hF);
  assign w_unlocked  = (r_guard == GUARD_KEY);
  assign w_wr_guard  = w_wr_ok && (w_idx == IDX_GUARD);
  assign w_wr_start  = w_wr_ok && (w_idx == IDX_START);
  assign w_wr_reset  = w_wr_ok && (w_idx == IDX_RESET);
  assign w_wr_stat   = w_wr_ok && (w_idx == IDX_STAT);
  assign w_wr_mask   = w_wr_ok && (w_idx == IDX_MASK);
  assign w_start_acc = w_wr_start && w_unlocked;
  assign w_reset_acc = w_wr_reset && w_unlocked;
  assign w_viol_set  = (w_wr_start || w_wr_reset) && !w_unlocked;
  assign w_done_rise = i_done & ~r_done_q;
  assign w_unused_bits = &{1'b0, i_peri_addr[31:6], i_peri_addr[1:0], i_peri_wdata[31:17]};

  assign w_int_stat = {15'b0, r_viol, 16'b0} | {{(32-N_CH){1'b0}}, r_done_stat};
  assign w_mask_rd  = {15'b0, r_mask_viol, 16'b0} | {{(32-N_CH){1'b0}}, r_mask_ch};
  assign o_peri_int = |(w_int_stat & w_mask_rd);

  always_comb begin
    w_rd_mux = 32'hFFFF_FFFF;
    case (w_idx)
      IDX_GUARD: w_rd_mux = {31'b0, w_unlocked};
      IDX_START: w_rd_mux = {{(32-N_CH){1'b0}}, o_start_en};
      IDX_RESET: w_rd_mux = {{(32-N_CH){1'b0}}, o_reset_en};
      IDX_STAT:  w_rd_mux = w_int_stat;
      IDX_MASK:  w_rd_mux = w_mask_rd;
      IDX_VER:   w_rd_mux = {16'h0002, 8'h00, NCH8};
      default:   w_rd_mux = 32'hFFFF_FFFF;
    endcase
  end

  // Guard relocks when the countdown reaches zero, unless a write reloads it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_guard      <= '0;
      r_relock_cnt <= '0;
    end else if (w_wr_guard) begin
      r_guard      <= i_peri_wdata[15:0];
      r_relock_cnt <= TMO_VAL;
    end else if (w_start_acc || w_reset_acc) begin
      r_relock_cnt <= TMO_VAL;
    end else if (w_unlocked && (r_relock_cnt != 16'd0)) begin
      r_relock_cnt <= r_relock_cnt - 16'd1;
      if (r_relock_cnt == 16'd1) r_guard <= '0;
    end
  end

  // A reset pulse overrides start for its channel; zero bits never shorten a pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_start_en <= '0;
      o_reset_en <= '0;
      for (int k = 0; k < N_CH; k++) r_pulse_cnt[k] <= '0;
    end else begin
      if (w_start_acc) o_start_en <= i_peri_wdata[N_CH-1:0];
      for (int k = 0; k < N_CH; k++) begin
        if (w_reset_acc && i_peri_wdata[k]) begin
          r_pulse_cnt[k] <= PULSE_VAL;
          o_reset_en[k]  <= 1'b1;
          o_start_en[k]  <= 1'b0;
        end else if (r_pulse_cnt[k] != 8'd0) begin
          r_pulse_cnt[k] <= r_pulse_cnt[k] - 8'd1;
          o_reset_en[k]  <= (r_pulse_cnt[k] != 8'd1);
        end
      end
    end
  end

  // Status bits: W1C clear first, then set events OR in so they win.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done_q    <= '0;
      r_done_stat <= '0;
      r_viol      <= 1'b0;
      r_mask_ch   <= '0;
      r_mask_viol <= 1'b0;
    end else begin
      r_done_q    <= i_done;
      r_done_stat <= (r_done_stat & ~(w_wr_stat ? i_peri_wdata[N_CH-1:0] : {N_CH{1'b0}}))
                     | w_done_rise;
      r_viol      <= (r_viol & ~(w_wr_stat && i_peri_wdata[16])) | w_viol_set;
      if (w_wr_mask) begin
        r_mask_ch   <= i_peri_wdata[N_CH-1:0];
        r_mask_viol <= i_peri_wdata[16];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_peri_ready <= 1'b0;
      o_peri_rdata <= '0;
    end else begin
      o_peri_ready <= i_peri_rden || i_peri_wren;
      if (i_peri_rden) o_peri_rdata <= w_rd_mux;
    end
  end

endmodule

// File: doc/dra_multi_peri.md
DRA_MULTI_PERI -- requirements
Module: dra_multi_peri

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of controlled DRA channels; legal range 1..8.
REQ-002 SHALL have parameter GUARD_KEY, default 16'h1234, meaning the unlock key for protected registers.
REQ-003 SHALL have parameter GUARD_TMO, default 255, meaning the auto-relock timeout in cycles; legal range 1..65535.
REQ-004 SHALL have parameter RST_PULSE, default 16, meaning the reset pulse length in cycles; legal range 1..255.
REQ-005 SHALL have port i_clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port o_reset_en  output  N_CH  per-channel DRA reset, registered.
REQ-008 SHALL have port o_start_en  output  N_CH  per-channel DRA start, registered.
REQ-009 SHALL have port i_done  input  N_CH  per-channel done level from the DRA, synchronous to i_clk.
REQ-010 SHALL have ports i_peri_rden and i_peri_wren  input  1 each  read and write request.
REQ-011 SHALL have ports i_peri_addr and i_peri_wdata  input  32 each, and i_peri_wstrb  input  4  byte strobes.
REQ-012 SHALL have ports o_peri_rdata  output  32, o_peri_ready  output  1, and o_peri_int  output  1.

Function
REQ-013 SHALL decode the register index from i_peri_addr[5:2]:
- 0 GUARD
- 1 START
- 2 RESET
- 3 INT_STAT
- 4 INT_MASK
- 5 VERSION
REQ-014 SHALL drive o_peri_ready high exactly one cycle after any cycle with i_peri_rden|i_peri_wren, as a one-cycle pulse per request cycle.
REQ-015 SHALL register o_peri_rdata one cycle after i_peri_rden, and hold it otherwise.
REQ-016 SHALL return on read:
- GUARD: {31'b0, unlocked}
- START: o_start_en, zero-extended
- RESET: o_reset_en, zero-extended
- INT_STAT: {15'b0, viol, 16'b0} | done_stat
- INT_MASK: mask register
- VERSION: {16'h0002, 8'h00, N_CH[7:0]}
- indices 6..15: 32'hFFFFFFFF
REQ-017 SHALL accept a write only when i_peri_wstrb==4'hF; other strobe patterns are ignored but still acknowledged.
REQ-018 SHALL perform the write when rden and wren coincide, with rdata reflecting the pre-write value.
REQ-019 SHALL load guard[15:0] from wdata[15:0] on a GUARD write; unlocked = (guard==GUARD_KEY).
REQ-020 SHALL reload a 16-bit relock counter to GUARD_TMO on a GUARD write and on every accepted START/RESET write, decrement it while unlocked and nonzero, and clear guard to 0 in the cycle it reaches 0.
REQ-021 SHALL treat START and RESET as protected: a write while locked changes no output and sets sticky viol (bit 16 of INT_STAT).
REQ-022 SHALL load o_start_en <= wdata[N_CH-1:0] on an unlocked START write.
REQ-023 SHALL, on an unlocked RESET write, for each channel k with wdata[k]=1:
- assert o_reset_en[k] for exactly RST_PULSE cycles starting the next cycle;
- clear o_start_en[k] in that same cycle;
- reload the pulse counter if re-triggered while active.
REQ-024 SHALL ignore RESET write bits of 0; software cannot truncate an active pulse.
REQ-025 SHALL set done_stat[k] on a rising edge of i_done[k], detected against a registered copy of i_done.
REQ-026 SHALL clear each done_stat and viol bit on an INT_STAT write of 1 to that bit (W1C); a write of 0 has no effect.
REQ-027 SHALL let a set event win over a clear when both hit the same INT_STAT bit in the same cycle.
REQ-028 SHALL store mask bits [N_CH-1:0] and [16] from an INT_MASK write; INT_MASK is unprotected and other bits read 0.
REQ-029 SHALL drive o_peri_int = |(INT_STAT & INT_MASK) from registered state, with no combinational path from request inputs.
REQ-030 SHALL ignore writes to VERSION and to indices 6..15.

Reset
REQ-031 SHALL, on i_rst_n low, clear the following asynchronously: o_reset_en, o_start_en, guard, relock counter, pulse counters, done_stat, viol, mask, the i_done history register, o_peri_rdata and o_peri_ready; o_peri_int follows to 0.
REQ-032 SHALL abort any active reset pulse or relock countdown when reset is asserted mid-operation, and leave the block locked after release.

Verification
REQ-033 SHALL be covered by a guard scenario: write GUARD=1234, then START=0x5 -> o_start_en=4'b0101; wait GUARD_TMO+1 cycles, write START=0xF -> o_start_en stays 0101, INT_STAT bit16=1.
REQ-034 SHALL be covered by a reset-pulse scenario: unlocked, start_en=4'b1111, write RESET=0x2 -> o_reset_en[1] high for exactly 16 cycles, o_start_en=4'b1101; re-write RESET=0x2 at pulse cycle 10 -> 26 cycles high in total.
REQ-035 SHALL be covered by an interrupt scenario: mask=0x1, i_done[0] 0->1 -> INT_STAT=0x1 and o_peri_int=1; a write of INT_STAT=0x1 coincident with a new i_done[0] edge -> bit stays 1.
REQ-036 SHALL be covered by a decode scenario: read VERSION -> 0x00020004; read index 7 -> 0xFFFFFFFF; write START with wstrb=4'h3 -> ignored, ready still pulses once.
REQ-037 SHALL be covered by a mid-operation reset scenario: assert i_rst_n low during an active RESET pulse -> all outputs 0 immediately; after release, GUARD reads 0 and START writes are rejected.
